// File: rtl/watch_pkg.sv
// watch_pkg: state codes, field limits, reset time and calendar helpers for watch_date_set
// State codes double as the edit_field output (RUN=0, year=1 ... second=6).
package watch_pkg;

    localparam logic [2:0] ST_RUN   = 3'd0;
    localparam logic [2:0] ST_YEAR  = 3'd1;
    localparam logic [2:0] ST_MONTH = 3'd2;
    localparam logic [2:0] ST_DAY   = 3'd3;
    localparam logic [2:0] ST_HOUR  = 3'd4;
    localparam logic [2:0] ST_MIN   = 3'd5;
    localparam logic [2:0] ST_SEC   = 3'd6;

    localparam logic [7:0] SEC_MAX   = 8'd59;
    localparam logic [7:0] MIN_MAX   = 8'd59;
    localparam logic [7:0] HOUR_MAX  = 8'd23;
    localparam logic [7:0] MONTH_MAX = 8'd12;

    localparam logic [7:0] RST_YEAR   = 8'd0;
    localparam logic [7:0] RST_MONTH  = 8'd1;
    localparam logic [7:0] RST_DAY    = 8'd1;
    localparam logic [7:0] RST_HOUR   = 8'd0;
    localparam logic [7:0] RST_MINUTE = 8'd0;
    localparam logic [7:0] RST_SECOND = 8'd0;

    // Years 2000..2099 only, so divisibility by 4 is the whole leap rule.
    function automatic logic [7:0] days_in_month(input logic [7:0] month, input logic [7:0] year);
        if (month == 8'd2) return ((year & 8'd3) == 8'd0) ? 8'd29 : 8'd28;
        return (month == 8'd4 || month == 8'd6 || month == 8'd9 || month == 8'd11) ? 8'd30 : 8'd31;
    endfunction

    function automatic logic [7:0] wrap_step(input logic [7:0] v, input logic [7:0] lo,
                                             input logic [7:0] hi, input logic up);
        return up ? ((v == hi) ? lo : v + 8'd1) : ((v == lo) ? hi : v - 8'd1);
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// sw_debounce: per-bit 2-flop synchroniser, debounce counter and press pulse
// Ports: clk, rst (async active-low), sw_in raw switches, press one-cycle 0->1 pulses.
module sw_debounce #(
    parameter int WIDTH      = 4,
    parameter int DEB_CYCLES = 500_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] press
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync2_q, level_q, level_d, press_q, press_d, flip;
    logic [CW-1:0] cnt_q [WIDTH];
    logic [CW-1:0] cnt_d [WIDTH];

    // The counter measures how long the synchronised level has differed from
    // the accepted one; any cycle of agreement restarts it.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            flip[i]    = (sync2_q[i] != level_q[i]) && (cnt_q[i] == CNT_LAST);
            cnt_d[i]   = (sync2_q[i] == level_q[i] || flip[i]) ? '0 : cnt_q[i] + CW'(1);
            level_d[i] = level_q[i] ^ flip[i];
            press_d[i] = flip[i] & ~level_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            press_q <= '0;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q <= sw_in;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/watch_date_set.sv
// watch_date_set: 1 Hz calendar clock with debounced switch-driven set mode
// Ports: clk, rst (async active-low), sw_in {exit, down, up, mode};
// year/month/day/hour/minute/second binary fields, tick_1hz, setting, edit_field, blink.
module watch_date_set
    import watch_pkg::*;
#(
    parameter int TICK_DIV   = 50_000_000,
    parameter int DEB_CYCLES = 500_000,
    parameter int YEAR_MAX   = 99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw_in,
    output logic [7:0] year,
    output logic [7:0] month,
    output logic [7:0] day,
    output logic [7:0] hour,
    output logic [7:0] minute,
    output logic [7:0] second,
    output logic       tick_1hz,
    output logic       setting,
    output logic [2:0] edit_field,
    output logic       blink
);

    localparam int DW = $clog2(TICK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(TICK_DIV / 2 - 1);
    localparam logic [7:0] YMAX = 8'(YEAR_MAX);

    logic [3:0] press;
    logic ev_mode, ev_up, ev_dn, ev_exit, div_last;
    logic [7:0] year_q, year_d, month_q, month_d, day_q, day_d;
    logic [7:0] hour_q, hour_d, minute_q, minute_d, second_q, second_d;
    logic [7:0] dim_q, dim_d;
    logic [DW-1:0] div_q, div_d;
    logic [2:0] state_q, state_d;
    logic tick_q, tick_d, blink_q, blink_d;

    sw_debounce #(.WIDTH(4), .DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk   (clk),
        .rst   (rst),
        .sw_in (sw_in),
        .press (press)
    );

    assign ev_mode  = press[0];
    assign ev_up    = press[1];
    assign ev_dn    = press[2];
    assign ev_exit  = press[3];
    assign div_last = (div_q == DIV_LAST);
    assign dim_q    = days_in_month(month_q, year_q);

    always_comb begin
        year_d   = year_q;
        month_d  = month_q;
        day_d    = day_q;
        hour_d   = hour_q;
        minute_d = minute_q;
        second_d = second_q;
        state_d  = state_q;
        blink_d  = blink_q;
        tick_d   = 1'b0;
        div_d    = div_last ? '0 : div_q + DW'(1);
        if (state_q == ST_RUN) begin
            tick_d = div_last;
            if (div_last) begin
                second_d = wrap_step(second_q, 8'd0, SEC_MAX, 1'b1);
                if (second_q == SEC_MAX) begin
                    minute_d = wrap_step(minute_q, 8'd0, MIN_MAX, 1'b1);
                    if (minute_q == MIN_MAX) begin
                        hour_d = wrap_step(hour_q, 8'd0, HOUR_MAX, 1'b1);
                        if (hour_q == HOUR_MAX) begin
                            day_d = wrap_step(day_q, 8'd1, dim_q, 1'b1);
                            if (day_q == dim_q) begin
                                month_d = wrap_step(month_q, 8'd1, MONTH_MAX, 1'b1);
                                if (month_q == MONTH_MAX) year_d = wrap_step(year_q, 8'd0, YMAX, 1'b1);
                            end
                        end
                    end
                end
            end
            // A same-cycle tick still lands; only the state and blink timer restart.
            if (ev_mode) begin
                state_d = ST_YEAR;
                div_d   = '0;
                blink_d = 1'b1;
            end
        end else if (ev_exit) begin
            state_d = ST_RUN;
            div_d   = '0;
            blink_d = 1'b0;
        end else begin
            blink_d = blink_q ^ (div_last || div_q == DIV_HALF);
            if (ev_mode) begin
                state_d = (state_q == ST_SEC) ? ST_YEAR : state_q + 3'd1;
            end else if (ev_up ^ ev_dn) begin
                case (state_q)
                    ST_YEAR:  year_d   = wrap_step(year_q, 8'd0, YMAX, ev_up);
                    ST_MONTH: month_d  = wrap_step(month_q, 8'd1, MONTH_MAX, ev_up);
                    ST_DAY:   day_d    = wrap_step(day_q, 8'd1, dim_q, ev_up);
                    ST_HOUR:  hour_d   = wrap_step(hour_q, 8'd0, HOUR_MAX, ev_up);
                    ST_MIN:   minute_d = wrap_step(minute_q, 8'd0, MIN_MAX, ev_up);
                    ST_SEC:   second_d = wrap_step(second_q, 8'd0, SEC_MAX, ev_up);
                    default: ;
                endcase
            end
        end
        // Month/year edits can shrink the month under the current day.
        dim_d = days_in_month(month_d, year_d);
        if (day_d > dim_d) day_d = dim_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            year_q   <= RST_YEAR;
            month_q  <= RST_MONTH;
            day_q    <= RST_DAY;
            hour_q   <= RST_HOUR;
            minute_q <= RST_MINUTE;
            second_q <= RST_SECOND;
            div_q    <= '0;
            state_q  <= ST_RUN;
            tick_q   <= 1'b0;
            blink_q  <= 1'b0;
        end else begin
            year_q   <= year_d;
            month_q  <= month_d;
            day_q    <= day_d;
            hour_q   <= hour_d;
            minute_q <= minute_d;
            second_q <= second_d;
            div_q    <= div_d;
            state_q  <= state_d;
            tick_q   <= tick_d;
            blink_q  <= blink_d;
        end
    end

    assign year       = year_q;
    assign month      = month_q;
    assign day        = day_q;
    assign hour       = hour_q;
    assign minute     = minute_q;
    assign second     = second_q;
    assign tick_1hz   = tick_q;
    assign setting    = (state_q != ST_RUN);
    assign edit_field = state_q;
    assign blink      = blink_q;

endmodule

// File: tb/tb_watch_date_set.sv
// tb_watch_date_set: calendar-model scoreboard plus directed set-mode scenarios
module tb_watch_date_set;

    localparam int TD = 10;
    localparam int DB = 4;
    localparam int YM = 99;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [3:0] sw = '0;
    logic [7:0] year, month, day, hour, minute, second;
    logic tick_1hz, setting, blink;
    logic [2:0] edit_field;
    int total = 0;
    int bad = 0;

    int m_f [7];
    int m_st, m_div, m_blink, m_tick;
    int run [4];
    logic [3:0] s1, s2, lvl, m_press;

    watch_date_set #(.TICK_DIV(TD), .DEB_CYCLES(DB), .YEAR_MAX(YM)) dut (
        .clk        (clk),
        .rst        (rst),
        .sw_in      (sw),
        .year       (year),
        .month      (month),
        .day        (day),
        .hour       (hour),
        .minute     (minute),
        .second     (second),
        .tick_1hz   (tick_1hz),
        .setting    (setting),
        .edit_field (edit_field),
        .blink      (blink)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dim(input int m, input int y);
        if (m == 2) return (y % 4 == 0) ? 29 : 28;
        if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
        return 31;
    endfunction

    // Fields indexed by edit_field code: 1=year .. 6=second.
    function automatic int lo_of(input int f);
        return (f == 2 || f == 3) ? 1 : 0;
    endfunction

    function automatic int hi_of(input int f);
        case (f)
            1: return YM;
            2: return 12;
            3: return dim(m_f[2], m_f[1]);
            4: return 23;
            default: return 59;
        endcase
    endfunction

    function automatic int dut_field(input int f);
        case (f)
            1: return int'(year);
            2: return int'(month);
            3: return int'(day);
            4: return int'(hour);
            5: return int'(minute);
            default: return int'(second);
        endcase
    endfunction

    task automatic m_reset();
        m_f = '{0, 0, 1, 1, 0, 0, 0};
        m_st = 0;
        m_div = 0;
        m_blink = 0;
        m_tick = 0;
        run = '{0, 0, 0, 0};
        s1 = '0;
        s2 = '0;
        lvl = '0;
        m_press = '0;
    endtask

    task automatic m_advance();
        bit carry;
        carry = 1'b1;
        for (int i = 6; i >= 1; i--) begin
            if (carry) begin
                if (m_f[i] == hi_of(i)) m_f[i] = lo_of(i);
                else begin
                    m_f[i]++;
                    carry = 1'b0;
                end
            end
        end
    endtask

    task automatic m_bump(input int f, input bit up);
        if (up) m_f[f] = (m_f[f] == hi_of(f)) ? lo_of(f) : m_f[f] + 1;
        else m_f[f] = (m_f[f] == lo_of(f)) ? hi_of(f) : m_f[f] - 1;
        if (m_f[3] > dim(m_f[2], m_f[1])) m_f[3] = dim(m_f[2], m_f[1]);
    endtask

    task automatic m_step();
        logic [3:0] ev, np;
        ev = m_press;
        m_tick = 0;
        if (m_st == 0) begin
            if (m_div == TD - 1) begin
                m_div = 0;
                m_tick = 1;
                m_advance();
            end else m_div++;
            if (ev[0]) begin
                m_st = 1;
                m_div = 0;
                m_blink = 1;
            end
        end else if (ev[3]) begin
            m_st = 0;
            m_div = 0;
            m_blink = 0;
        end else begin
            if (m_div == TD / 2 - 1 || m_div == TD - 1) m_blink = 1 - m_blink;
            m_div = (m_div == TD - 1) ? 0 : m_div + 1;
            if (ev[0]) m_st = (m_st == 6) ? 1 : m_st + 1;
            else if (ev[1] != ev[2]) m_bump(m_st, ev[1]);
        end
        np = '0;
        for (int b = 0; b < 4; b++) begin
            if (s2[b] != lvl[b]) begin
                run[b]++;
                if (run[b] == DB) begin
                    lvl[b] = s2[b];
                    run[b] = 0;
                    np[b] = s2[b];
                end
            end else run[b] = 0;
        end
        m_press = np;
        s2 = s1;
        s1 = sw;
    endtask

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) m_reset();
        else m_step();
    end

    initial forever begin
        @(negedge clk);
        for (int f = 1; f <= 6; f++) chk("field", dut_field(f), m_f[f]);
        chk("tick_1hz", int'(tick_1hz), m_tick);
        chk("setting", int'(setting), int'(m_st != 0));
        chk("edit_field", int'(edit_field), m_st);
        chk("blink", int'(blink), m_blink);
    end

    task automatic press(input int b);
        sw[b] = 1'b1;
        repeat (8) @(negedge clk);
        sw[b] = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic goto_field(input int f);
        for (int k = 0; k < 8 && m_st != f; k++) press(0);
        chk("goto_field", int'(edit_field), f);
    endtask

    task automatic adjust_to(input int f, input int target);
        goto_field(f);
        for (int k = 0; k < 40 && m_f[f] != target; k++) begin
            int range, d;
            range = hi_of(f) - lo_of(f) + 1;
            d = (target - m_f[f] + range) % range;
            press((d <= range / 2) ? 1 : 2);
        end
        chk("adjust", dut_field(f), target);
    endtask

    task automatic set_time(input int y, input int mo, input int d, input int h, input int mi, input int s);
        adjust_to(1, y);
        adjust_to(2, mo);
        adjust_to(3, d);
        adjust_to(4, h);
        adjust_to(5, mi);
        adjust_to(6, s);
    endtask

    task automatic exit_tick(input int y, input int mo, input int d, input int h, input int mi, input int s);
        press(3);
        chk("exit_edit", int'(edit_field), 0);
        chk("exit_blink", int'(blink), 0);
        chk("pre_tick", int'(tick_1hz), 0);
        @(negedge clk);
        chk("tick_after_exit", int'(tick_1hz), 1);
        chk("t_year", int'(year), y);
        chk("t_month", int'(month), mo);
        chk("t_day", int'(day), d);
        chk("t_hour", int'(hour), h);
        chk("t_minute", int'(minute), mi);
        chk("t_second", int'(second), s);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_year"}, int'(year), 0);
        chk({tag, "_month"}, int'(month), 1);
        chk({tag, "_day"}, int'(day), 1);
        chk({tag, "_hms"}, int'(hour) + int'(minute) + int'(second), 0);
        chk({tag, "_tick"}, int'(tick_1hz), 0);
        chk({tag, "_setting"}, int'(setting), 0);
        chk({tag, "_edit"}, int'(edit_field), 0);
        chk({tag, "_blink"}, int'(blink), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_reset("rst");
        rst = 1'b1;
        repeat (9) @(negedge clk);
        chk("no_early_tick", int'(tick_1hz), 0);
        @(negedge clk);
        chk("first_tick", int'(tick_1hz), 1);
        chk("first_second", int'(second), 1);
        repeat (590) @(negedge clk);
        chk("minute_600", int'(minute), 1);
        chk("second_600", int'(second), 0);

        set_time(3, 12, 31, 23, 59, 59);
        exit_tick(4, 1, 1, 0, 0, 0);
        set_time(4, 2, 28, 23, 59, 59);
        exit_tick(4, 2, 29, 0, 0, 0);
        set_time(5, 2, 28, 23, 59, 59);
        exit_tick(5, 3, 1, 0, 0, 0);
        set_time(99, 12, 31, 23, 59, 59);
        exit_tick(0, 1, 1, 0, 0, 0);

        sw[0] = 1'b1;
        repeat (7) @(negedge clk);
        chk("enter_setting", int'(setting), 1);
        chk("enter_edit", int'(edit_field), 1);
        for (int k = 0; k < 15; k++) begin
            chk("blink_phase", int'(blink), int'((k / 5) % 2 == 0));
            @(negedge clk);
        end
        sw[0] = 1'b0;
        repeat (8) @(negedge clk);

        adjust_to(1, 4);
        adjust_to(2, 3);
        adjust_to(3, 31);
        goto_field(2);
        press(2);
        chk("clamp_month", int'(month), 2);
        chk("clamp_day_leap", int'(day), 29);
        goto_field(1);
        press(1);
        chk("year_up", int'(year), 5);
        chk("clamp_day_year", int'(day), 28);
        adjust_to(2, 3);
        adjust_to(3, 31);
        goto_field(2);
        press(2);
        chk("clamp_day_common", int'(day), 28);

        for (int k = 0; k < 6; k++) begin
            sw[1] = 1'b1;
            @(negedge clk);
            sw[1] = 1'b0;
            @(negedge clk);
        end
        for (int k = 0; k < 3; k++) begin
            sw[1] = 1'b1;
            repeat (3) @(negedge clk);
            sw[1] = 1'b0;
            repeat (2) @(negedge clk);
        end
        repeat (8) @(negedge clk);
        chk("bounce_month", int'(month), 2);

        sw[1] = 1'b1;
        sw[2] = 1'b1;
        repeat (8) @(negedge clk);
        sw = '0;
        repeat (8) @(negedge clk);
        chk("updown_month", int'(month), 2);
        chk("updown_edit", int'(edit_field), 2);

        sw[0] = 1'b1;
        sw[3] = 1'b1;
        repeat (8) @(negedge clk);
        sw = '0;
        repeat (8) @(negedge clk);
        chk("exit_mode_edit", int'(edit_field), 0);
        chk("exit_mode_setting", int'(setting), 0);

        goto_field(5);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk_reset("async");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        chk("tick_after_reset", int'(tick_1hz), 1);
        chk("second_after_reset", int'(second), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
